// File: rtl/lighthouse_pkg.sv
// Shared constants, state encoding and sync-code helper for the lighthouse pulse decoder.
package lighthouse_pkg;

  localparam int unsigned DefMinPulse   = 25;
  localparam int unsigned DefSweepMax   = 1000;
  localparam int unsigned DefSyncMin    = 2500;
  localparam int unsigned DefSyncOffset = 2865;
  localparam int unsigned DefSyncStep   = 521;
  localparam int unsigned DefPairGap    = 25000;
  localparam int unsigned DefTsW        = 20;

  localparam int unsigned PW_W = 13;

  // Bit positions inside the {skip, data, axis} sync code
  localparam int unsigned SYNC_AXIS = 0;
  localparam int unsigned SYNC_SKIP = 2;

  typedef enum logic [0:0] {StIdle, StHigh} state_e;

  // Count of bin thresholds met; thresholds are elaboration constants, so no divider is built
  function automatic logic [2:0] sync_code_of(input logic [PW_W-1:0] width,
                                               input int unsigned offset,
                                               input int unsigned step);
    logic [2:0] code;
    code = '0;
    for (int unsigned k = 1; k <= 7; k++) begin
      if (32'(width) >= offset + k * step) code = code + 3'd1;
    end
    return code;
  endfunction

endpackage

// File: rtl/lighthouse_pulse_decoder_if.sv
// Sensor-side control/envelope inputs and decoded sync/sweep outputs of one decoder.
interface lighthouse_pulse_decoder_if #(
  parameter int unsigned TS_W = lighthouse_pkg::DefTsW
);
  logic            en;
  logic            envelope;
  logic            sync_valid;
  logic            sync_lighthouse;
  logic [2:0]      sync_code;
  logic            sweep_valid;
  logic            sweep_lighthouse;
  logic            sweep_axis;
  logic [TS_W-1:0] sweep_ts;
  logic [10:0]     sweep_width;

  modport master (
    output en, envelope,
    input  sync_valid, sync_lighthouse, sync_code,
    input  sweep_valid, sweep_lighthouse, sweep_axis, sweep_ts, sweep_width
  );

  modport slave (
    input  en, envelope,
    output sync_valid, sync_lighthouse, sync_code,
    output sweep_valid, sweep_lighthouse, sweep_axis, sweep_ts, sweep_width
  );
endinterface

// File: rtl/lh_edge_detect.sv
// Synchronises the raw envelope pin, normalises it to light = 1 and strobes rise/fall.
module lh_edge_detect #(
  parameter bit ActiveHigh = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic env_i,
  output logic rise_o,
  output logic fall_o
);
  logic [1:0] sync_q;
  logic       level_q;
  logic       level;

  assign level = ActiveHigh ? sync_q[1] : ~sync_q[1];

  // Reset to the dark pin level so leaving reset never fakes a rise
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q  <= {2{~ActiveHigh}};
      level_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], env_i};
      level_q <= level;
    end
  end

  assign rise_o = level & ~level_q;
  assign fall_o = ~level & level_q;
endmodule

// File: rtl/lighthouse_pulse_decoder.sv
// Measures envelope pulse widths, decodes sync codes and timestamps the first sweep per sync.
module lighthouse_pulse_decoder #(
  parameter bit          ENV_ACTIVE_HIGH = 1'b1,
  parameter int unsigned MIN_PULSE       = lighthouse_pkg::DefMinPulse,
  parameter int unsigned SWEEP_MAX       = lighthouse_pkg::DefSweepMax,
  parameter int unsigned SYNC_MIN        = lighthouse_pkg::DefSyncMin,
  parameter int unsigned SYNC_OFFSET     = lighthouse_pkg::DefSyncOffset,
  parameter int unsigned SYNC_STEP       = lighthouse_pkg::DefSyncStep,
  parameter int unsigned PAIR_GAP        = lighthouse_pkg::DefPairGap,
  parameter int unsigned TS_W            = lighthouse_pkg::DefTsW
) (
  input logic                       clk,
  input logic                       reset,
  lighthouse_pulse_decoder_if.slave bus
);
  import lighthouse_pkg::*;

  localparam logic [PW_W-1:0] PwSat      = '1;
  localparam logic [PW_W-1:0] MinPw      = PW_W'(MIN_PULSE);
  localparam logic [PW_W-1:0] SweepMaxPw = PW_W'(SWEEP_MAX);
  localparam logic [PW_W-1:0] SyncMinPw  = PW_W'(SYNC_MIN);
  localparam logic [TS_W-1:0] PairGap    = TS_W'(PAIR_GAP);
  localparam logic [TS_W-1:0] AgeMax     = '1;

  logic env_rise, env_fall;

  lh_edge_detect #(
    .ActiveHigh (ENV_ACTIVE_HIGH)
  ) u_edge (
    .clk_i  (clk),
    .rst_i  (reset),
    .env_i  (bus.envelope),
    .rise_o (env_rise),
    .fall_o (env_fall)
  );

  state_e            state_q, state_d;
  logic [PW_W-1:0]   width_q, width_d;
  logic [TS_W-1:0]   now_q, rise_t_q, rise_t_d;
  logic              armed_q, armed_d, armed_lh_q, armed_lh_d, armed_axis_q, armed_axis_d;
  logic [TS_W-1:0]   armed_ref_q, armed_ref_d, armed_age_q, armed_age_d;
  logic              prev_sync_q, prev_sync_d;
  logic [TS_W-1:0]   sync_age_q, sync_age_d;
  logic              sync_valid_q, sync_valid_d, sync_lh_q, sync_lh_d;
  logic [2:0]        sync_code_q, sync_code_d;
  logic              sweep_valid_q, sweep_valid_d, sweep_lh_q, sweep_lh_d;
  logic              sweep_axis_q, sweep_axis_d;
  logic [TS_W-1:0]   sweep_ts_q, sweep_ts_d;
  logic [10:0]       sweep_width_q, sweep_width_d;

  logic [2:0] code;
  logic       pair_lh;
  logic       armed_live;

  assign code       = sync_code_of(width_q, SYNC_OFFSET, SYNC_STEP);
  assign pair_lh    = prev_sync_q && (sync_age_q < PairGap);
  assign armed_live = armed_q && (armed_age_q != AgeMax);

  always_comb begin
    state_d       = state_q;
    width_d       = width_q;
    rise_t_d      = rise_t_q;
    armed_d       = armed_live;
    armed_ref_d   = armed_ref_q;
    armed_lh_d    = armed_lh_q;
    armed_axis_d  = armed_axis_q;
    armed_age_d   = (armed_age_q == AgeMax) ? armed_age_q : armed_age_q + TS_W'(1);
    prev_sync_d   = prev_sync_q;
    sync_age_d    = (sync_age_q == AgeMax) ? sync_age_q : sync_age_q + TS_W'(1);
    sync_valid_d  = 1'b0;
    sync_lh_d     = sync_lh_q;
    sync_code_d   = sync_code_q;
    sweep_valid_d = 1'b0;
    sweep_lh_d    = sweep_lh_q;
    sweep_axis_d  = sweep_axis_q;
    sweep_ts_d    = sweep_ts_q;
    sweep_width_d = sweep_width_q;

    if (!bus.en) begin
      state_d     = StIdle;
      armed_d     = 1'b0;
      prev_sync_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (env_rise) begin
            rise_t_d = now_q;
            width_d  = PW_W'(1);
            state_d  = StHigh;
          end
        end
        StHigh: begin
          if (env_fall) begin
            state_d = StIdle;
            if (width_q == PwSat) begin
              armed_d = 1'b0;
            end else if (width_q >= SyncMinPw) begin
              sync_valid_d = 1'b1;
              sync_lh_d    = pair_lh;
              sync_code_d  = code;
              sync_age_d   = '0;
              prev_sync_d  = 1'b1;
              if (!code[SYNC_SKIP]) begin
                armed_d      = 1'b1;
                armed_ref_d  = rise_t_q;
                armed_lh_d   = pair_lh;
                armed_axis_d = code[SYNC_AXIS];
                armed_age_d  = '0;
              end
            end else if (width_q >= MinPw && width_q < SweepMaxPw && armed_live) begin
              sweep_valid_d = 1'b1;
              sweep_lh_d    = armed_lh_q;
              sweep_axis_d  = armed_axis_q;
              // Centre of the sweep, measured from the armed sync's rising edge
              sweep_ts_d    = (rise_t_q - armed_ref_q) + TS_W'(width_q >> 1);
              sweep_width_d = width_q[10:0];
              armed_d       = 1'b0;
            end
          end else if (width_q != PwSat) begin
            width_d = width_q + PW_W'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      width_q       <= '0;
      now_q         <= '0;
      rise_t_q      <= '0;
      armed_q       <= 1'b0;
      armed_ref_q   <= '0;
      armed_lh_q    <= 1'b0;
      armed_axis_q  <= 1'b0;
      armed_age_q   <= '0;
      prev_sync_q   <= 1'b0;
      sync_age_q    <= '0;
      sync_valid_q  <= 1'b0;
      sync_lh_q     <= 1'b0;
      sync_code_q   <= '0;
      sweep_valid_q <= 1'b0;
      sweep_lh_q    <= 1'b0;
      sweep_axis_q  <= 1'b0;
      sweep_ts_q    <= '0;
      sweep_width_q <= '0;
    end else begin
      state_q       <= state_d;
      width_q       <= width_d;
      now_q         <= now_q + TS_W'(1);
      rise_t_q      <= rise_t_d;
      armed_q       <= armed_d;
      armed_ref_q   <= armed_ref_d;
      armed_lh_q    <= armed_lh_d;
      armed_axis_q  <= armed_axis_d;
      armed_age_q   <= armed_age_d;
      prev_sync_q   <= prev_sync_d;
      sync_age_q    <= sync_age_d;
      sync_valid_q  <= sync_valid_d;
      sync_lh_q     <= sync_lh_d;
      sync_code_q   <= sync_code_d;
      sweep_valid_q <= sweep_valid_d;
      sweep_lh_q    <= sweep_lh_d;
      sweep_axis_q  <= sweep_axis_d;
      sweep_ts_q    <= sweep_ts_d;
      sweep_width_q <= sweep_width_d;
    end
  end

  assign bus.sync_valid       = sync_valid_q;
  assign bus.sync_lighthouse  = sync_lh_q;
  assign bus.sync_code        = sync_code_q;
  assign bus.sweep_valid      = sweep_valid_q;
  assign bus.sweep_lighthouse = sweep_lh_q;
  assign bus.sweep_axis       = sweep_axis_q;
  assign bus.sweep_ts         = sweep_ts_q;
  assign bus.sweep_width      = sweep_width_q;
endmodule
